// File: rtl/rx_capture_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rx_capture_ctrl : locks to O_HS/O_VS, opens an active window and writes one |
// |   frame linearly into the frame-buffer BRAM. Optional macro: RX_DECIMATE_EN |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module rx_capture_ctrl #(
   parameter int H_START  = 144,
   parameter int V_START  = 35,
   parameter int H_ACTIVE = 128,
   parameter int V_ACTIVE = 96,
   parameter int DEPTH    = 16384
) (
   input  logic       O_CLK,
   input  logic       RESET_N,
   input  logic       ENABLE,
   input  logic       O_HS,
   input  logic       O_VS,
   input  logic [9:0] VIDEO,
   output logic [7:0] BRAM_DIN,
   output logic [13:0] BRAM_ADDR,
   output logic       BRAM_WE,
   output logic       SYNC,
   output logic       FRAME_DONE,
   output logic       OVERFLOW,
   output logic       RESYNC
);
   // Wide enough for H_ACTIVE*V_ACTIVE at the limits, so the address never wraps.
   localparam int ADDR_W = 20;
   localparam int H_LAST = H_START - 1;
   localparam int V_LAST = V_START - 1;
   localparam int P_LAST = H_ACTIVE - 1;
   localparam int L_LAST = V_ACTIVE - 1;
`ifdef RX_DECIMATE_EN
   localparam int LINE_STEP = H_ACTIVE / 2;
`else
   localparam int LINE_STEP = H_ACTIVE;
`endif
   localparam logic [11:0]       C_H_LAST = H_LAST[11:0];
   localparam logic [9:0]        C_V_LAST = V_LAST[9:0];
   localparam logic [9:0]        C_P_LAST = P_LAST[9:0];
   localparam logic [8:0]        C_L_LAST = L_LAST[8:0];
   localparam logic [ADDR_W-1:0] C_STEP   = LINE_STEP[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] C_DEPTH  = DEPTH[ADDR_W-1:0];

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VS = 3'd1,
      V_SKIP  = 3'd2,
      H_SKIP  = 3'd3,
      ACTIVE  = 3'd4,
      H_WAIT  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               hs_dly_q, vs_dly_q;
   logic [9:0]         v_cnt_q, v_cnt_d;
   logic [11:0]        h_cnt_q, h_cnt_d;
   logic [9:0]         pix_cnt_q, pix_cnt_d;
   logic [8:0]         line_cnt_q, line_cnt_d;
   logic [ADDR_W-1:0]  line_base_q, line_base_d;
   logic [7:0]         din_q, din_d;
   logic [13:0]        addr_q, addr_d;
   logic               we_q, we_d;
   logic               sync_q, sync_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               resync_q, resync_d;

   logic               hs_rise, vs_rise, take_pix;
   logic [ADDR_W-1:0]  pix_off, wr_addr;
   logic               video_lsb_unused;

   assign hs_rise = O_HS & ~hs_dly_q;
   assign vs_rise = O_VS & ~vs_dly_q;
   assign video_lsb_unused = ^VIDEO[1:0];

`ifdef RX_DECIMATE_EN
   assign take_pix = ~pix_cnt_q[0];
   assign pix_off  = {{(ADDR_W-9){1'b0}}, pix_cnt_q[9:1]};
`else
   assign take_pix = 1'b1;
   assign pix_off  = {{(ADDR_W-10){1'b0}}, pix_cnt_q};
`endif
   assign wr_addr = line_base_q + pix_off;

   always_comb begin
      state_d     = state_q;
      v_cnt_d     = v_cnt_q;
      h_cnt_d     = h_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      line_cnt_d  = line_cnt_q;
      line_base_d = line_base_q;
      din_d       = din_q;
      addr_d      = addr_q;
      we_d        = 1'b0;
      sync_d      = 1'b0;
      done_d      = 1'b0;
      ovf_d       = ovf_q;
      resync_d    = 1'b0;
      if (!ENABLE) begin
         state_d = IDLE;
      end else if (vs_rise && state_q != IDLE) begin
         // Accepted frame start; anywhere past WAIT_VS it also aborts the frame.
         sync_d      = 1'b1;
         resync_d    = (state_q != WAIT_VS);
         ovf_d       = 1'b0;
         v_cnt_d     = '0;
         line_cnt_d  = '0;
         line_base_d = '0;
         state_d     = V_SKIP;
      end else begin
         case (state_q)
            IDLE:    state_d = WAIT_VS;
            WAIT_VS: state_d = WAIT_VS;
            V_SKIP: begin
               if (hs_rise) begin
                  if (v_cnt_q == C_V_LAST) begin
                     state_d   = H_SKIP;
                     h_cnt_d   = '0;
                     pix_cnt_d = '0;
                  end else begin
                     v_cnt_d = v_cnt_q + 10'd1;
                  end
               end
            end
            H_SKIP: begin
               if (h_cnt_q == C_H_LAST) state_d = ACTIVE;
               else                     h_cnt_d = h_cnt_q + 12'd1;
            end
            ACTIVE: begin
               if (take_pix) begin
                  if (wr_addr < C_DEPTH) begin
                     we_d   = 1'b1;
                     addr_d = wr_addr[13:0];
                     din_d  = VIDEO[9:2];
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               if (pix_cnt_q == C_P_LAST) begin
                  pix_cnt_d   = '0;
                  line_cnt_d  = line_cnt_q + 9'd1;
                  line_base_d = line_base_q + C_STEP;
                  if (line_cnt_q == C_L_LAST) begin
                     done_d  = 1'b1;
                     state_d = WAIT_VS;
                  end else begin
                     state_d = H_WAIT;
                  end
               end else begin
                  pix_cnt_d = pix_cnt_q + 10'd1;
               end
            end
            H_WAIT: begin
               if (hs_rise) begin
                  state_d = H_SKIP;
                  h_cnt_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge O_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         hs_dly_q    <= 1'b0;
         vs_dly_q    <= 1'b0;
         v_cnt_q     <= '0;
         h_cnt_q     <= '0;
         pix_cnt_q   <= '0;
         line_cnt_q  <= '0;
         line_base_q <= '0;
         din_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         sync_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         resync_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hs_dly_q    <= O_HS;
         vs_dly_q    <= O_VS;
         v_cnt_q     <= v_cnt_d;
         h_cnt_q     <= h_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         line_cnt_q  <= line_cnt_d;
         line_base_q <= line_base_d;
         din_q       <= din_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         sync_q      <= sync_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         resync_q    <= resync_d;
      end
   end

   assign BRAM_DIN   = din_q;
   assign BRAM_ADDR  = addr_q;
   assign BRAM_WE    = we_q;
   assign SYNC       = sync_q;
   assign FRAME_DONE = done_q;
   assign OVERFLOW   = ovf_q;
   assign RESYNC     = resync_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_capture_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_rx_capture_ctrl : randomized frames against a pixel-window reference     |
// |   model with a write scoreboard. Follows RX_DECIMATE_EN when defined.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_rx_capture_ctrl;
   localparam int H_START  = 4;
   localparam int V_START  = 3;
   localparam int H_ACTIVE = 8;
   localparam int V_ACTIVE = 6;
   localparam int DEPTH    = 40;
`ifdef RX_DECIMATE_EN
   localparam int STEP = H_ACTIVE / 2;
`else
   localparam int STEP = H_ACTIVE;
`endif

   logic        O_CLK = 1'b0;
   logic        RESET_N, ENABLE, O_HS, O_VS;
   logic [9:0]  VIDEO;
   logic [7:0]  BRAM_DIN;
   logic [13:0] BRAM_ADDR;
   logic        BRAM_WE, SYNC, FRAME_DONE, OVERFLOW, RESYNC;

   rx_capture_ctrl #(
      .H_START(H_START), .V_START(V_START), .H_ACTIVE(H_ACTIVE),
      .V_ACTIVE(V_ACTIVE), .DEPTH(DEPTH)
   ) dut (
      .O_CLK(O_CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .O_HS(O_HS),
      .O_VS(O_VS), .VIDEO(VIDEO), .BRAM_DIN(BRAM_DIN), .BRAM_ADDR(BRAM_ADDR),
      .BRAM_WE(BRAM_WE), .SYNC(SYNC), .FRAME_DONE(FRAME_DONE),
      .OVERFLOW(OVERFLOW), .RESYNC(RESYNC)
   );

   always #5 O_CLK = ~O_CLK;

   typedef struct packed {
      logic [13:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  exp_q[$];
   int   n_checks = 0, n_pass = 0;
   int   exp_sync = 0, exp_done = 0, exp_resync = 0;
   int   seen_sync = 0, seen_done = 0, seen_resync = 0;
   int   wr_since_sync = 0;
   logic exp_ovf = 1'b0;
   logic ovf_prev = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   // Expected byte for frame address a, using the pixel currently on VIDEO.
   task automatic push(input int a);
      wr_t e;
      if (a < DEPTH) begin
         e.addr = a[13:0];
         e.data = VIDEO[9:2];
         exp_q.push_back(e);
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   always @(negedge O_CLK) begin : monitor
      wr_t e;
      if (RESET_N) begin
         if (SYNC) begin
            seen_sync++;
            wr_since_sync = 0;
            check("ovf_clear_at_sync", OVERFLOW, 0);
         end
         if (RESYNC) begin
            seen_resync++;
            check("resync_with_sync", SYNC, 1);
         end
         if (BRAM_WE) begin
            wr_since_sync++;
            if (exp_q.size() == 0) begin
               check("unexpected_write_addr", BRAM_ADDR, -1);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", BRAM_ADDR, e.addr);
               check("wr_data", BRAM_DIN, e.data);
            end
         end
         if (OVERFLOW && !ovf_prev) begin
            check("ovf_rise_write_count", wr_since_sync, DEPTH);
            check("ovf_rise_we_low", BRAM_WE, 0);
         end
         if (FRAME_DONE) begin
            seen_done++;
            check("done_queue_empty", exp_q.size(), 0);
         end
         ovf_prev = OVERFLOW;
      end
   end

   // ev_kind: 0 none, 1 early VS at cycle ev_k, 2 ENABLE drop at cycle ev_k.
   task automatic drive_line(input bit cap, input int line, input int ev_k,
                             input int ev_kind, output bit hit);
      int len, hsw, p;
      len = $urandom_range(14, 24);
      hsw = $urandom_range(1, 3);
      hit = 1'b0;
      for (int k = 0; k < len; k++) begin
         @(negedge O_CLK);
         O_HS  = (k < hsw);
         VIDEO = 10'($urandom);
         if (k == ev_k && ev_kind == 1) begin
            O_VS = 1'b1;
            hit = 1'b1;
            exp_sync++;
            exp_resync++;
            exp_ovf = 1'b0;
            return;
         end
         if (k == ev_k && ev_kind == 2) begin
            ENABLE = 1'b0;
            hit = 1'b1;
         end
         p = k - H_START - 1;
         if (cap && !hit && p >= 0 && p < H_ACTIVE) begin
`ifdef RX_DECIMATE_EN
            if (p % 2 == 0) push(line * STEP + p / 2);
`else
            push(line * STEP + p);
`endif
         end
      end
   endtask

   task automatic frame(input bit acc, input bit vs_hs, input bit skip_vs,
                        input int ev_line, input int ev_k, input int ev_kind);
      bit hit, cap, reen;
      cap  = acc;
      reen = 1'b0;
      if (skip_vs) begin
         @(negedge O_CLK);
         O_VS = 1'b1;
         O_HS = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            @(negedge O_CLK);
            O_VS = 1'b1;
            O_HS = vs_hs;
         end
         if (acc) begin
            exp_sync++;
            exp_ovf = 1'b0;
         end
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge O_CLK);
         O_VS = 1'b0;
         O_HS = 1'b0;
      end
      for (int i = 0; i < V_START - 1; i++) drive_line(1'b0, 0, -1, 0, hit);
      for (int l = 0; l < V_ACTIVE; l++) begin
         if (reen) ENABLE = 1'b1;
         drive_line(cap, l, (l == ev_line) ? ev_k : -1, ev_kind, hit);
         if (hit && ev_kind == 1) return;
         if (hit) begin
            cap  = 1'b0;
            reen = 1'b1;
         end
      end
      if (reen) ENABLE = 1'b1;
      if (cap) exp_done++;
      drive_line(1'b0, 0, -1, 0, hit);
      check("frame_end_overflow", OVERFLOW, exp_ovf);
   endtask

   initial begin
      RESET_N = 1'b0;
      ENABLE  = 1'b0;
      O_HS    = 1'b0;
      O_VS    = 1'b0;
      VIDEO   = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge O_CLK);
         O_HS  = 1'($urandom);
         O_VS  = 1'($urandom);
         VIDEO = 10'($urandom);
      end
      @(negedge O_CLK);
      check("rst_we", BRAM_WE, 0);
      check("rst_addr", BRAM_ADDR, 0);
      check("rst_din", BRAM_DIN, 0);
      check("rst_sync", SYNC, 0);
      check("rst_done", FRAME_DONE, 0);
      check("rst_ovf", OVERFLOW, 0);
      check("rst_resync", RESYNC, 0);
      RESET_N = 1'b1;
      O_HS    = 1'b0;
      O_VS    = 1'b0;

      frame(1'b0, 1'b0, 1'b0, -1, -1, 0);
      check("idle_addr_held", BRAM_ADDR, 0);

      @(negedge O_CLK);
      ENABLE = 1'b1;
      repeat (3) @(negedge O_CLK);
      frame(1'b1, 1'b0, 1'b0, -1, -1, 0);
      frame(1'b1, 1'b0, 1'b0, -1, -1, 0);
      frame(1'b1, 1'b1, 1'b0, -1, -1, 0);
      frame(1'b1, 1'b0, 1'b0, 2, $urandom_range(H_START + 2, H_START + H_ACTIVE), 1);
      frame(1'b1, 1'b0, 1'b1, -1, -1, 0);
      frame(1'b1, 1'b0, 1'b0, 1, $urandom_range(H_START + 2, H_START + H_ACTIVE), 2);
      frame(1'b1, 1'b0, 1'b0, -1, -1, 0);
      for (int f = 0; f < 3; f++) frame(1'b1, 1'($urandom), 1'b0, -1, -1, 0);

      repeat (10) @(negedge O_CLK);
      check("sync_count", seen_sync, exp_sync);
      check("done_count", seen_done, exp_done);
      check("resync_count", seen_resync, exp_resync);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
